rmii_rx_framer: RTL and testbench

RMII_RX_FRAMER -- requirements
Module: rmii_rx_framer

---
 rtl/rmii_rx_framer.sv | 141 ++++++++++++++
 tb/tb_rmii_rx_framer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rmii_rx_framer.sv
// RMII receive framer: hunts for a valid preamble and SFD, then streams the
// frame payload out one dibit per clock with registered outclk/out strobes.
// Frame end, odd-length frames and oversized frames are reported through
// done/err pulses.
module rmii_rx_framer #(
    parameter int MIN_PREAMBLE_DIBITS = 12,
    parameter int MAX_FRAME_DIBITS    = 6088
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       crs_dv,
    input  logic [1:0] rxd,
    output logic [1:0] out,
    output logic       outclk,
    output logic       done,
    output logic       err,
    output logic       busy
);

    localparam int PCW = ($clog2(MIN_PREAMBLE_DIBITS + 1) > 0) ? $clog2(MIN_PREAMBLE_DIBITS + 1) : 1;
    localparam int DCW = ($clog2(MAX_FRAME_DIBITS + 1) > 0) ? $clog2(MAX_FRAME_DIBITS + 1) : 1;
    localparam logic [PCW-1:0] PRE_MIN  = PCW'(MIN_PREAMBLE_DIBITS);
    localparam logic [DCW-1:0] DATA_MAX = DCW'(MAX_FRAME_DIBITS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DROP     = 2'd3
    } state_t;

    state_t         state, state_next;
    logic [PCW-1:0] pre_cnt, pre_cnt_next;
    logic [DCW-1:0] data_cnt, data_cnt_next;
    logic [1:0]     s1_dibit, s1_dibit_next;
    logic           s1_flag, s1_flag_next;
    logic           s1_valid, s1_valid_next;
    logic [1:0]     out_next;
    logic           outclk_next, done_next, err_next;

    // State, counters, stage-1 holding register and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            pre_cnt  <= '0;
            data_cnt <= '0;
            s1_dibit <= 2'b00;
            s1_flag  <= 1'b0;
            s1_valid <= 1'b0;
            out      <= 2'b00;
            outclk   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_next;
            pre_cnt  <= pre_cnt_next;
            data_cnt <= data_cnt_next;
            s1_dibit <= s1_dibit_next;
            s1_flag  <= s1_flag_next;
            s1_valid <= s1_valid_next;
            out      <= out_next;
            outclk   <= outclk_next;
            done     <= done_next;
            err      <= err_next;
        end
    end

    // Next-state and output decisions; s1_flag doubles as "crs_dv last cycle"
    // so the two-low-cycles end condition can be checked in DATA and DROP
    always_comb begin
        state_next    = state;
        pre_cnt_next  = pre_cnt;
        data_cnt_next = data_cnt;
        s1_dibit_next = rxd;
        s1_flag_next  = crs_dv;
        s1_valid_next = (state == DATA);
        out_next      = out;
        outclk_next   = 1'b0;
        done_next     = 1'b0;
        err_next      = 1'b0;

        case (state)
            IDLE: begin
                if (crs_dv) begin
                    case (rxd)
                        2'b01: begin
                            state_next   = PREAMBLE;
                            pre_cnt_next = PCW'(1);
                        end
                        2'b10, 2'b11: state_next = DROP;
                        default:      state_next = IDLE;
                    endcase
                end
            end

            PREAMBLE: begin
                if (!crs_dv) begin
                    state_next = IDLE;
                end else if (rxd == 2'b01) begin
                    if (pre_cnt < PRE_MIN) begin
                        pre_cnt_next = pre_cnt + PCW'(1);
                    end
                end else if ((rxd == 2'b11) && (pre_cnt >= PRE_MIN)) begin
                    state_next    = DATA;
                    data_cnt_next = '0;
                end else begin
                    state_next = DROP;
                end
            end

            DATA: begin
                if (s1_valid && (s1_flag || crs_dv)) begin
                    if (data_cnt == DATA_MAX) begin
                        done_next  = 1'b1;
                        err_next   = 1'b1;
                        state_next = DROP;
                    end else begin
                        out_next      = s1_dibit;
                        outclk_next   = 1'b1;
                        data_cnt_next = data_cnt + DCW'(1);
                    end
                end else if (!s1_flag && !crs_dv) begin
                    done_next  = 1'b1;
                    err_next   = ((data_cnt & DCW'(3)) != '0);
                    state_next = IDLE;
                end
            end

            DROP: begin
                if (!s1_flag && !crs_dv) begin
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_rmii_rx_framer.sv
// Self-checking bench for rmii_rx_framer: directed frames with hand-derived
// expectations plus a long randomized stream compared every cycle against a
// behavioural model of the framing rules.
module tb_rmii_rx_framer;

    localparam int MIN_PRE = 12;
    localparam int MAX_DIB = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       crs_dv = 1'b0;
    logic [1:0] rxd = 2'b00;
    logic [1:0] out;
    logic       outclk, done, err, busy;

    int testsRun = 0;
    int testsFailed = 0;

    rmii_rx_framer #(
        .MIN_PREAMBLE_DIBITS(MIN_PRE),
        .MAX_FRAME_DIBITS(MAX_DIB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .crs_dv(crs_dv),
        .rxd(rxd),
        .out(out),
        .outclk(outclk),
        .done(done),
        .err(err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural model state, expressed in terms of the frame rules
    typedef enum {M_IDLE, M_PRE, M_DATA, M_DROP} mode_t;
    mode_t      mode = M_IDLE;
    int         preCount = 0;
    int         emitted = 0;
    bit         havePrev = 1'b0;
    bit         lastC = 1'b0;
    logic [1:0] lastD = 2'b00;
    bit         expOutclk = 1'b0, expDone = 1'b0, expErr = 1'b0, expBusy = 1'b0;
    logic [1:0] expOut = 2'b00;

    // Capture of what the DUT actually produced, for directed checks
    logic [1:0] got[$];
    int doneCount = 0, doneErrCount = 0, errCount = 0;
    int cyc = 0, lastOutclkCycle = 0, lastDoneCycle = 0;
    bit checkEn = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock edge of the reference: what the outputs must be next cycle
    task automatic modelStep(input bit r, input bit c, input logic [1:0] d);
        expOutclk = 1'b0;
        expDone   = 1'b0;
        expErr    = 1'b0;
        if (!r) begin
            mode     = M_IDLE;
            preCount = 0;
            emitted  = 0;
            havePrev = 1'b0;
            expOut   = 2'b00;
            lastC    = 1'b0;
            lastD    = 2'b00;
        end else begin
            case (mode)
                M_IDLE: begin
                    if (c && d == 2'b01) begin
                        mode = M_PRE;
                        preCount = 1;
                    end else if (c && d != 2'b00) begin
                        mode = M_DROP;
                    end
                end
                M_PRE: begin
                    if (!c) mode = M_IDLE;
                    else if (d == 2'b01) preCount = (preCount < MIN_PRE) ? preCount + 1 : preCount;
                    else if (d == 2'b11 && preCount >= MIN_PRE) begin
                        mode = M_DATA;
                        emitted = 0;
                        havePrev = 1'b0;
                    end else mode = M_DROP;
                end
                M_DATA: begin
                    if (havePrev && (lastC || c)) begin
                        if (emitted == MAX_DIB) begin
                            expDone = 1'b1;
                            expErr = 1'b1;
                            mode = M_DROP;
                        end else begin
                            expOutclk = 1'b1;
                            expOut = lastD;
                            emitted++;
                        end
                    end else if (havePrev && !lastC && !c) begin
                        expDone = 1'b1;
                        expErr = (emitted % 4) != 0;
                        mode = M_IDLE;
                    end
                    havePrev = 1'b1;
                end
                M_DROP: begin
                    if (!lastC && !c) mode = M_IDLE;
                end
                default: mode = M_IDLE;
            endcase
            lastC = c;
            lastD = d;
        end
        expBusy = (mode != M_IDLE);
    endtask

    // Reference advances on every rising edge with the inputs the DUT samples
    initial begin
        forever begin
            @(posedge clk);
            modelStep(reset, crs_dv, rxd);
        end
    end

    // Compare DUT outputs against the reference every cycle, on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (checkEn) begin
                checkOutput("outclk", {31'd0, outclk}, {31'd0, expOutclk});
                checkOutput("done", {31'd0, done}, {31'd0, expDone});
                checkOutput("err", {31'd0, err}, {31'd0, expErr});
                checkOutput("busy", {31'd0, busy}, {31'd0, expBusy});
                checkOutput("out", {30'd0, out}, {30'd0, expOut});
                if (outclk === 1'b1) begin
                    got.push_back(out);
                    lastOutclkCycle = cyc;
                end
                if (done === 1'b1) begin
                    doneCount++;
                    lastDoneCycle = cyc;
                    if (err === 1'b1) doneErrCount++;
                end
                if (err === 1'b1) errCount++;
            end
        end
    end

    task automatic applyStimulus(input bit c, input logic [1:0] d);
        crs_dv = c;
        rxd = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 2'b00);
    endtask

    task automatic sendPreamble(input int n, input logic [1:0] sfd);
        repeat (n) applyStimulus(1'b1, 2'b01);
        applyStimulus(1'b1, sfd);
    endtask

    task automatic sendByte(input logic [7:0] b, input logic [3:0] crsPat);
        for (int i = 0; i < 4; i++) applyStimulus(crsPat[i], b[2*i +: 2]);
    endtask

    task automatic clearCapture();
        got.delete();
        doneCount = 0;
        doneErrCount = 0;
        errCount = 0;
    endtask

    logic [1:0] expNormal[8] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b11, 2'b00};
    logic [1:0] expToggle[4] = '{2'b11, 2'b10, 2'b10, 2'b10};

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkEn = 1'b1;
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_outclk", {31'd0, outclk}, 32'd0);
        checkOutput("reset_out", {30'd0, out}, 32'd0);
        reset = 1'b1;
        idleCycles(3);

        // Normal frame 0x12 0x34 after a long preamble
        clearCapture();
        sendPreamble(28, 2'b11);
        sendByte(8'h12, 4'hF);
        sendByte(8'h34, 4'hF);
        idleCycles(4);
        checkOutput("normal_count", got.size(), 32'd8);
        for (int i = 0; i < 8 && i < got.size(); i++)
            checkOutput($sformatf("normal_dibit%0d", i), {30'd0, got[i]}, {30'd0, expNormal[i]});
        checkOutput("normal_done", doneCount, 32'd1);
        checkOutput("normal_err", errCount, 32'd0);
        checkOutput("normal_done_gap", lastDoneCycle - lastOutclkCycle, 32'd1);

        // crs_dv toggling across the final byte still yields all four dibits
        clearCapture();
        sendPreamble(12, 2'b11);
        sendByte(8'h55, 4'hF);
        sendByte(8'hAB, 4'b1010);
        idleCycles(3);
        checkOutput("toggle_count", got.size(), 32'd8);
        for (int i = 0; i < 4 && i + 4 < got.size(); i++)
            checkOutput($sformatf("toggle_dibit%0d", i), {30'd0, got[i+4]}, {30'd0, expToggle[i]});
        checkOutput("toggle_done", doneCount, 32'd1);
        checkOutput("toggle_err", errCount, 32'd0);

        // Short preamble is dropped silently
        clearCapture();
        sendPreamble(4, 2'b11);
        repeat (3) applyStimulus(1'b1, 2'b10);
        applyStimulus(1'b0, 2'b00);
        checkOutput("short_busy_one_low", {31'd0, busy}, 32'd1);
        applyStimulus(1'b0, 2'b00);
        checkOutput("short_busy_two_low", {31'd0, busy}, 32'd0);
        idleCycles(2);
        checkOutput("short_count", got.size(), 32'd0);
        checkOutput("short_done", doneCount, 32'd0);
        checkOutput("short_err", errCount, 32'd0);

        // Odd length frame of three dibits
        clearCapture();
        sendPreamble(12, 2'b11);
        applyStimulus(1'b1, 2'b10);
        applyStimulus(1'b1, 2'b01);
        applyStimulus(1'b1, 2'b11);
        idleCycles(3);
        checkOutput("odd_count", got.size(), 32'd3);
        checkOutput("odd_done", doneCount, 32'd1);
        checkOutput("odd_done_with_err", doneErrCount, 32'd1);

        // Oversized frame: 20 dibits against a 16-dibit limit
        clearCapture();
        sendPreamble(12, 2'b11);
        repeat (20) applyStimulus(1'b1, 2'($urandom_range(0, 3)));
        idleCycles(3);
        checkOutput("over_count", got.size(), 32'd16);
        checkOutput("over_done", doneCount, 32'd1);
        checkOutput("over_done_with_err", doneErrCount, 32'd1);
        checkOutput("over_slot", lastDoneCycle - lastOutclkCycle, 32'd1);
        checkOutput("over_busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of the payload aborts without done/err
        clearCapture();
        sendPreamble(12, 2'b11);
        repeat (5) applyStimulus(1'b1, 2'($urandom_range(0, 3)));
        reset = 1'b0;
        applyStimulus(1'b1, 2'b11);
        reset = 1'b1;
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_outclk", {31'd0, outclk}, 32'd0);
        repeat (8) applyStimulus(1'b1, 2'b10);
        idleCycles(3);
        checkOutput("rst_count", got.size(), 32'd4);
        checkOutput("rst_done", doneCount, 32'd0);
        checkOutput("rst_err", errCount, 32'd0);

        // Randomized frames, noise and resets against the reference model
        for (int f = 0; f < 80; f++) begin
            int preLen;
            int dataLen;
            bit toggleEnd;
            idleCycles($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                repeat (6) applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
                idleCycles(2);
            end
            preLen = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 11) : $urandom_range(12, 20);
            sendPreamble(preLen, ($urandom_range(0, 9) == 0) ? 2'b10 : 2'b11);
            dataLen = $urandom_range(0, 22);
            toggleEnd = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < dataLen; i++) begin
                bit c;
                c = (toggleEnd && (i >= dataLen - 4)) ? 1'($urandom_range(0, 1)) : 1'b1;
                if ($urandom_range(0, 149) == 0) reset = 1'b0;
                applyStimulus(c, 2'($urandom_range(0, 3)));
                reset = 1'b1;
            end
            idleCycles($urandom_range(2, 4));
        end
        idleCycles(4);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
